// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and stall controller for the 5-stage RV32I core.
// Detects load-use hazards between ID and EX, applies taken-branch flushes,
// freezes the pipe while data memory is busy (remembering any branch that
// resolves during the freeze), and keeps saturating performance counters.

module hazard_ctrl #(
  parameter int LU_BUBBLES = 1,   // bubbles per load-use hazard, 1..4
  parameter int CNT_W      = 32   // performance counter width
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_MemRead,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  input  logic             cnt_clear,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic [1:0]       busy_state
);

  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_LU_STALL = 2'd1;
  localparam logic [1:0] S_MEM_WAIT = 2'd2;

  // Extra bubbles after the first one, loaded into bcnt on hazard entry.
  localparam logic [2:0] BCNT_INIT = 3'(LU_BUBBLES - 1);

  logic [1:0] state, state_nxt;
  logic       pend_flush, pend_nxt;
  logic [2:0] bcnt, bcnt_nxt;
  logic       lu;
  logic       flush_fire;
  logic       run_active;
  logic       taken_eff;

  // Load-use: the EX load writes a register the ID instruction reads.
  // x0 is never a real producer, so ex_rd == 0 cannot raise a hazard.
  assign lu = ex_MemRead && (ex_rd != 5'd0) &&
              ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
               (id_uses_rs2 && (id_rs2 == ex_rd)));

  assign busy_state = state;

  // Next-state and control-output decode.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    ex_mem_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    flush_fire  = 1'b0;
    state_nxt   = state;
    pend_nxt    = pend_flush;
    bcnt_nxt    = bcnt;
    run_active  = 1'b0;
    taken_eff   = ex_branch_taken;

    case (state)
      S_RUN: begin
        if (mem_busy) begin
          // Freeze everything; a branch resolving now must survive the wait.
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          ex_mem_en = 1'b0;
          pend_nxt  = ex_branch_taken;
          state_nxt = S_MEM_WAIT;
        end else begin
          run_active = 1'b1;
        end
      end

      S_LU_STALL: begin
        pc_en    = 1'b0;
        if_id_en = 1'b0;
        if (mem_busy) begin
          // Back end is frozen too: hold the bubble count, inject nothing.
          ex_mem_en = 1'b0;
        end else begin
          id_ex_flush = 1'b1;
          bcnt_nxt    = bcnt - 3'd1;
          if (bcnt <= 3'd1) begin
            bcnt_nxt  = 3'd0;
            state_nxt = S_RUN;
          end
        end
      end

      S_MEM_WAIT: begin
        if (mem_busy) begin
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          ex_mem_en = 1'b0;
          pend_nxt  = pend_flush | ex_branch_taken;
        end else begin
          // Release cycle: replay the RUN rules with any branch that was
          // taken while frozen folded in.
          run_active = 1'b1;
          taken_eff  = ex_branch_taken | pend_flush;
          pend_nxt   = 1'b0;
          state_nxt  = S_RUN;
        end
      end

      default: begin
        state_nxt = S_RUN;
        pend_nxt  = 1'b0;
        bcnt_nxt  = 3'd0;
      end
    endcase

    // Shared RUN rules: a taken branch outranks a load-use hazard because
    // the dependent instruction is about to be squashed anyway.
    if (run_active) begin
      if (taken_eff) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        flush_fire  = 1'b1;
      end else if (lu) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
        if (LU_BUBBLES > 1) begin
          bcnt_nxt  = BCNT_INIT;
          state_nxt = S_LU_STALL;
        end
      end
    end

    // Reset forces a free-running, flush-free pipe regardless of inputs.
    if (rst) begin
      pc_en       = 1'b1;
      if_id_en    = 1'b1;
      ex_mem_en   = 1'b1;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      flush_fire  = 1'b0;
    end
  end

  // FSM state, pending-branch flag and bubble counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_RUN;
      pend_flush <= 1'b0;
      bcnt       <= 3'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      state      <= state_nxt;
      pend_flush <= pend_nxt;
      bcnt       <= bcnt_nxt;
    end
  end

  // Saturating stall-cycle counter; clear wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (cnt_clear) begin
      stall_cycles <= '0;
    end else if (!pc_en && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

  // Saturating branch-flush counter; clear wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_events <= '0;
    end else if (cnt_clear) begin
      flush_events <= '0;
    end else if (flush_fire && (flush_events != '1)) begin
      flush_events <= flush_events + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl. Two instances share one stimulus stream:
// dut_a uses one load-use bubble and wide counters, dut_b uses three bubbles
// and 4-bit counters so saturation is reachable quickly. Expected outputs
// are queued per step and compared at the falling edge.

module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_MemRead;
  logic       ex_branch_taken, mem_busy, cnt_clear;

  logic        a_pc_en, a_if_id_en, a_if_id_flush, a_id_ex_flush, a_ex_mem_en;
  logic [31:0] a_stall_cycles, a_flush_events;
  logic [1:0]  a_busy_state;
  logic        b_pc_en, b_if_id_en, b_if_id_flush, b_id_ex_flush, b_ex_mem_en;
  logic [3:0]  b_stall_cycles, b_flush_events;
  logic [1:0]  b_busy_state;

  int errors = 0;
  int checks = 0;

  // Control vector order: {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en}
  localparam logic [4:0] DEF = 5'b11001;  // free running
  localparam logic [4:0] LUS = 5'b00011;  // load-use bubble
  localparam logic [4:0] BR  = 5'b11111;  // branch redirect, squash two
  localparam logic [4:0] FRZ = 5'b00000;  // full freeze

  typedef struct {
    string       tag;
    bit          which;   // 0 = dut_a, 1 = dut_b
    logic [4:0]  ctrl;
    logic [1:0]  st;
    logic [31:0] sc;
    logic [31:0] fe;
  } exp_t;

  exp_t sb[$];

  hazard_ctrl #(.LU_BUBBLES(1), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_MemRead(ex_MemRead), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .cnt_clear(cnt_clear),
    .pc_en(a_pc_en), .if_id_en(a_if_id_en),
    .if_id_flush(a_if_id_flush), .id_ex_flush(a_id_ex_flush),
    .ex_mem_en(a_ex_mem_en),
    .stall_cycles(a_stall_cycles), .flush_events(a_flush_events),
    .busy_state(a_busy_state)
  );

  hazard_ctrl #(.LU_BUBBLES(3), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_MemRead(ex_MemRead), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .cnt_clear(cnt_clear),
    .pc_en(b_pc_en), .if_id_en(b_if_id_en),
    .if_id_flush(b_if_id_flush), .id_ex_flush(b_id_ex_flush),
    .ex_mem_en(b_ex_mem_en),
    .stall_cycles(b_stall_cycles), .flush_events(b_flush_events),
    .busy_state(b_busy_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog: the directed sequence is a few hundred ns long.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input bit which, input logic [4:0] ctrl,
                            input logic [1:0] st, input int unsigned sc, input int unsigned fe);
    exp_t e;
    e.tag = tag; e.which = which; e.ctrl = ctrl; e.st = st; e.sc = sc; e.fe = fe;
    sb.push_back(e);
  endtask

  task automatic expect_both(input string tag, input logic [4:0] ca, input logic [1:0] sa,
                             input int unsigned sca, input int unsigned fea,
                             input logic [4:0] cb, input logic [1:0] sbs,
                             input int unsigned scb, input int unsigned feb);
    expect_out(tag, 1'b0, ca, sa, sca, fea);
    expect_out(tag, 1'b1, cb, sbs, scb, feb);
  endtask

  task automatic compare_queue();
    exp_t        e;
    logic [4:0]  oc;
    logic [1:0]  os;
    logic [31:0] osc, ofe;
    string       n;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.which) begin
        oc  = {b_pc_en, b_if_id_en, b_if_id_flush, b_id_ex_flush, b_ex_mem_en};
        os  = b_busy_state;
        osc = {28'd0, b_stall_cycles};
        ofe = {28'd0, b_flush_events};
      end else begin
        oc  = {a_pc_en, a_if_id_en, a_if_id_flush, a_id_ex_flush, a_ex_mem_en};
        os  = a_busy_state;
        osc = a_stall_cycles;
        ofe = a_flush_events;
      end
      n = $sformatf("%s/%s", e.tag, e.which ? "b" : "a");
      chk({n, ".ctrl"},  {27'd0, oc}, {27'd0, e.ctrl});
      chk({n, ".state"}, {30'd0, os}, {30'd0, e.st});
      chk({n, ".stall"}, osc, e.sc);
      chk({n, ".flush"}, ofe, e.fe);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    compare_queue();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                        input logic u2, input logic mr, input logic [4:0] rd,
                        input logic tk, input logic busy, input logic clr);
    id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    ex_MemRead = mr; ex_rd = rd; ex_branch_taken = tk; mem_busy = busy;
    cnt_clear = clr;
  endtask

  task automatic idle();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic hazard();
    set_in(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset with a live hazard on the inputs: outputs must stay forced.
    rst = 1'b1;
    hazard();
    #2;
    expect_both("reset", DEF, 2'd0, 0, 0, DEF, 2'd0, 0, 0);
    compare_queue();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();

    expect_both("idle", DEF, 2'd0, 0, 0, DEF, 2'd0, 0, 0);
    step();

    // Load-use: one bubble on dut_a, three on dut_b.
    hazard();
    expect_both("lu0", LUS, 2'd0, 0, 0, LUS, 2'd0, 0, 0);
    step();
    idle();
    expect_both("lu1", DEF, 2'd0, 1, 0, LUS, 2'd1, 1, 0);
    step();
    expect_both("lu2", DEF, 2'd0, 1, 0, LUS, 2'd1, 2, 0);
    step();
    expect_both("lu3", DEF, 2'd0, 1, 0, DEF, 2'd0, 3, 0);
    step();

    // Branch coincident with a load-use hazard: branch wins.
    set_in(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    expect_both("br_lu", BR, 2'd0, 1, 0, BR, 2'd0, 3, 0);
    step();
    idle();
    expect_both("br_after", DEF, 2'd0, 1, 1, DEF, 2'd0, 3, 1);
    step();

    // Branch taken in the first of four memory-busy cycles.
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    expect_both("mw0", FRZ, 2'd0, 1, 1, FRZ, 2'd0, 3, 1);
    step();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    expect_both("mw1", FRZ, 2'd2, 2, 1, FRZ, 2'd2, 4, 1);
    step();
    expect_both("mw2", FRZ, 2'd2, 3, 1, FRZ, 2'd2, 5, 1);
    step();
    expect_both("mw3", FRZ, 2'd2, 4, 1, FRZ, 2'd2, 6, 1);
    step();
    idle();
    expect_both("mw_rel", BR, 2'd2, 5, 1, BR, 2'd2, 7, 1);
    step();
    expect_both("mw_run", DEF, 2'd0, 5, 2, DEF, 2'd0, 7, 2);
    step();

    // Memory stall inside LU_STALL on dut_b, then async reset mid-stall.
    hazard();
    expect_both("lum0", LUS, 2'd0, 5, 2, LUS, 2'd0, 7, 2);
    step();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    expect_both("lum1", FRZ, 2'd0, 6, 2, FRZ, 2'd1, 8, 2);
    step();
    idle();
    expect_both("lum2", DEF, 2'd2, 7, 2, LUS, 2'd1, 9, 2);
    sample();
    #2;
    rst = 1'b1;
    #1;
    expect_both("rst_async", DEF, 2'd0, 0, 0, DEF, 2'd0, 0, 0);
    compare_queue();
    advance();
    rst = 1'b0;
    expect_both("post_rst", DEF, 2'd0, 0, 0, DEF, 2'd0, 0, 0);
    step();

    // Twenty consecutive stall cycles: dut_b's 4-bit counter saturates.
    hazard();
    repeat (20) @(posedge clk);
    #1;
    set_in(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
    expect_both("sat", LUS, 2'd0, 20, 0, LUS, 2'd1, 15, 0);
    step();
    idle();
    expect_both("clear", DEF, 2'd0, 0, 0, DEF, 2'd0, 0, 0);
    step();

    // Corner cases of hazard detection.
    set_in(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    expect_both("rd_zero", DEF, 2'd0, 0, 0, DEF, 2'd0, 0, 0);
    step();
    set_in(5'd7, 5'd7, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    expect_both("no_use", DEF, 2'd0, 0, 0, DEF, 2'd0, 0, 0);
    step();
    set_in(5'd3, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    expect_both("rs2_lu", LUS, 2'd0, 0, 0, LUS, 2'd0, 0, 0);
    step();
    idle();
    expect_both("rs2_after", DEF, 2'd0, 1, 0, LUS, 2'd1, 1, 0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage RV32I core. It drives the `flush` input of the ID/EX register and the enables and flushes of the other pipeline registers. It observes the instruction in ID, the instruction held in EX, the resolved branch outcome from EX, and the data-memory busy handshake. It also keeps saturating counters of stall cycles and branch flushes for performance monitoring.

## Interface
- `LU_BUBBLES`, default 1: bubbles inserted per load-use hazard. Legal range is 1..4.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `id_rs1`, `id_rs2`  in  5  source registers of the instruction in ID.
- `id_uses_rs1`, `id_uses_rs2`  in  1  the ID instruction actually reads rs1 / rs2.
- `ex_MemRead`  in  1  the EX instruction is a load (ID/EX `MemRead_out`).
- `ex_rd`  in  5  destination of the EX instruction (ID/EX `rd_out`).
- `ex_branch_taken`  in  1  branch or jump resolved taken in EX this cycle.
- `mem_busy`  in  1  data memory has not completed the MEM-stage access.
- `cnt_clear`  in  1  synchronous clear of both counters.
- `pc_en`  out  1  PC update enable.
- `if_id_en`  out  1  IF/ID register load enable.
- `if_id_flush`  out  1  squash IF/ID to NOP.
- `id_ex_flush`  out  1  drives the ID/EX register `flush`; inserts a NOP/bubble.
- `ex_mem_en`  out  1  EX/MEM and MEM/WB load enable.
- `stall_cycles`  out  CNT_W  count of cycles with `pc_en`=0.
- `flush_events`  out  CNT_W  count of branch-flush cycles.
- `busy_state`  out  2  FSM state: 0 RUN, 1 LU_STALL, 2 MEM_WAIT.

## Operation
- **Control outputs.** `pc_en`, `if_id_en`, `if_id_flush`, `id_ex_flush` and `ex_mem_en` are combinational from the state, the registered flags and the inputs.
- **Load-use condition.** `lu` = `ex_MemRead` & `ex_rd`≠0 & ((`id_uses_rs1` & `id_rs1`==`ex_rd`) | (`id_uses_rs2` & `id_rs2`==`ex_rd`)).
- **Defaults.** `pc_en`=`if_id_en`=`ex_mem_en`=1 and both flushes=0, unless a rule below overrides them.
- **RUN state.** Evaluated in priority order:
  - `mem_busy` → freeze: all three enables=0, no flush. `pend_flush` <= `ex_branch_taken`. Next state MEM_WAIT.
  - else `ex_branch_taken` → `if_id_flush`=`id_ex_flush`=1, `pc_en`=1 (redirect). Stay in RUN. A coincident `lu` is ignored.
  - else `lu` → `pc_en`=`if_id_en`=0, `id_ex_flush`=1. If `LU_BUBBLES`>1: `bcnt` <= `LU_BUBBLES`-1 and next state is LU_STALL.
- **LU_STALL state.** `pc_en`=`if_id_en`=0, `id_ex_flush`=1.
  - `bcnt` decrements each cycle. When `bcnt`==1 the next state is RUN.
  - `mem_busy` in this state → additionally `ex_mem_en`=0, `id_ex_flush`=0, and `bcnt` holds. The state stays LU_STALL.
- **MEM_WAIT state.**
  - While `mem_busy`=1: all enables=0, no flush. `pend_flush` <= `pend_flush` | `ex_branch_taken`.
  - First cycle with `mem_busy`=0: outputs follow the RUN rules with the effective taken = `ex_branch_taken` | `pend_flush`. `pend_flush` <= 0 and next state is RUN.
- **Counters.**
  - `stall_cycles` increments on every cycle with `pc_en`=0.
  - `flush_events` increments on every cycle where the branch-flush rule fires.
  - Both saturate at all-ones and do not wrap.
  - `cnt_clear` zeroes both and has priority over increment.

## Timing
- **Reset.** `rst` asserted sets state=RUN, `pend_flush`=0, `bcnt`=0, and both counters to 0.
  - While `rst`=1, outputs are forced to `pc_en`=`if_id_en`=`ex_mem_en`=1 with both flushes=0.
  - Mid-stall reset aborts the stall immediately.
- **Latency.** Hazard response is zero-cycle combinational. The effect of a flush or stall is visible at the next `clk` edge in the pipeline registers.
- **Load-use penalty.** Exactly `LU_BUBBLES` cycles of `pc_en`=0 per hazard when no memory stall occurs.
- **Branch penalty.** Exactly 1 flush cycle, which squashes 2 instructions (IF/ID and ID/EX).
- **Branch during a memory stall.** Never lost; the flush is applied in the cycle `mem_busy` falls.
- **No spurious load-use.** `ex_rd`=0 never raises `lu`.

## Test plan
- **Load-use, 1 bubble.** `ex_MemRead`=1, `ex_rd`=5, `id_rs1`=5, `id_uses_rs1`=1, LU_BUBBLES=1 → for 1 cycle `pc_en`=0, `if_id_en`=0, `id_ex_flush`=1; `stall_cycles` 0→1.
- **Load-use, 3 bubbles.** Same hazard with LU_BUBBLES=3 → `busy_state`=1 for 2 cycles; `pc_en`=0 for exactly 3 cycles; `stall_cycles`=3.
- **Branch wins over load-use.** `ex_branch_taken`=1 with a simultaneous `lu` → `if_id_flush`=`id_ex_flush`=1, `pc_en`=1; `flush_events`=1; `stall_cycles` unchanged.
- **Branch during memory stall.** `mem_busy`=1 for 4 cycles with `ex_branch_taken`=1 in the first → all enables 0 for 4 cycles, `busy_state`=2. In the 5th cycle `if_id_flush`=`id_ex_flush`=1, then state RUN.
- **Reset mid-stall.** Assert `rst` asynchronously during LU_STALL (bcnt=2) → `busy_state`=0, counters 0, enables 1, with no clock edge required.
- **Saturation and clear.** CNT_W=4 with 20 stall cycles → `stall_cycles`=15. Then `cnt_clear`=1 concurrent with a stall → 0.
